// File: rtl/instr_encoder_loader_if.sv
// Request/imem/status bundle between a program builder and instr_encoder_loader.
// Latency: none (wires only).
// Backpressure: req_ready from the loader; the master holds req_valid and fields until accepted.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
) ();
  // control pulses
  logic              start;
  logic              stop;
  // request channel
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [12:0]       req_imm;
  // instruction memory write port
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  // status
  logic [ADDR_W-1:0] count;
  logic              busy;
  logic              full;
  logic              done;
  logic              err;

  modport master (
    output start, stop, req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
    input  req_ready, imem_we, imem_addr, imem_wdata, count, busy, full, done, err
  );

  modport slave (
    input  start, stop, req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm,
    output req_ready, imem_we, imem_addr, imem_wdata, count, busy, full, done, err
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic add/sub/and/or/ld/sd/beq requests into RV64I words and streams them into imem.
// Latency: one cycle from handshake to imem write; one word per cycle sustained.
// Backpressure: req_ready only in RUN while fewer than DEPTH legal requests were accepted.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 64
) (
  input logic                   clk_i,
  input logic                   rst_i,
  instr_encoder_loader_if.slave bus_io
);

  // One extra bit so count==DEPTH is representable even when DEPTH==2**ADDR_W.
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_LD  = 3'd4;
  localparam logic [2:0] OP_SD  = 3'd5;
  localparam logic [2:0] OP_BEQ = 3'd6;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_SD = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     issued_q, issued_d;
  logic              pend_vld_q, pend_vld_d;
  logic [31:0]       pend_dat_q, pend_dat_d;

  logic [4:0]  rd_w, rs1_w, rs2_w;
  logic [12:0] imm_w;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        req_rdy;
  logic        accept;
  logic        good_acc;
  logic        bad_acc;
  logic        start_go;

  assign rd_w  = bus_io.req_rd;
  assign rs1_w = bus_io.req_rs1;
  assign rs2_w = bus_io.req_rs2;
  assign imm_w = bus_io.req_imm;

  // Encode the presented request and flag ops/immediates that have no legal encoding.
  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    case (bus_io.req_op)
      OP_ADD: enc_word = {7'b0000000, rs2_w, rs1_w, 3'b000, rd_w, OPC_R};
      OP_SUB: enc_word = {7'b0100000, rs2_w, rs1_w, 3'b000, rd_w, OPC_R};
      OP_AND: enc_word = {7'b0000000, rs2_w, rs1_w, 3'b111, rd_w, OPC_R};
      OP_OR:  enc_word = {7'b0000000, rs2_w, rs1_w, 3'b110, rd_w, OPC_R};
      OP_LD: begin
        // 12-bit I-type field: the 13-bit offset must sign-extend from bit 11
        enc_word  = {imm_w[11:0], rs1_w, 3'b011, rd_w, OPC_LD};
        enc_legal = (imm_w[12] == imm_w[11]);
      end
      OP_SD: begin
        enc_word  = {imm_w[11:5], rs2_w, rs1_w, 3'b011, imm_w[4:0], OPC_SD};
        enc_legal = (imm_w[12] == imm_w[11]);
      end
      OP_BEQ: begin
        // branch offsets are halfword aligned; bit 0 is not encodable
        enc_word  = {imm_w[12], imm_w[10:5], rs2_w, rs1_w, 3'b000,
                     imm_w[4:1], imm_w[11], OPC_BR};
        enc_legal = ~imm_w[0];
      end
      default: enc_legal = 1'b0;
    endcase
  end

  // Ready depends on registered state only, so it never combinationally follows req_valid.
  assign req_rdy  = (state_q == ST_RUN) && (issued_q < DEPTH_C);
  assign accept   = req_rdy && bus_io.req_valid;
  assign good_acc = accept && enc_legal;
  assign bad_acc  = accept && !enc_legal;
  assign start_go = bus_io.start && (state_q != ST_RUN);

  // Program-level state: a bad accepted request outranks a simultaneous stop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (bad_acc) begin
          state_d = ST_ERR;
        end else if (bus_io.stop) begin
          state_d = ST_DONE;
        end
      end
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus_io.start) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write pipeline and counters: a pending write always drains; start clears the counters last.
  always_comb begin
    pend_vld_d = good_acc;
    pend_dat_d = good_acc ? enc_word : 32'd0;
    ptr_d      = ptr_q;
    count_d    = count_q;
    issued_d   = issued_q;
    if (pend_vld_q) begin
      ptr_d   = ptr_q + 1'b1;
      count_d = count_q + 1'b1;
    end
    if (good_acc) begin
      issued_d = issued_q + 1'b1;
    end
    if (start_go) begin
      ptr_d    = BASE_C;
      count_d  = '0;
      issued_d = '0;
    end
  end

  // State and pipeline registers; reset drops any in-flight write immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ptr_q      <= BASE_C;
      count_q    <= '0;
      issued_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_dat_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      pend_vld_q <= pend_vld_d;
      pend_dat_q <= pend_dat_d;
    end
  end

  assign bus_io.req_ready  = req_rdy;
  assign bus_io.imem_we    = pend_vld_q;
  assign bus_io.imem_addr  = pend_vld_q ? ptr_q : '0;
  assign bus_io.imem_wdata = pend_dat_q;
  assign bus_io.count      = count_q[ADDR_W-1:0];
  assign bus_io.busy       = (state_q == ST_RUN);
  assign bus_io.full       = (state_q == ST_RUN) && (count_q == DEPTH_C);
  assign bus_io.done       = (state_q == ST_DONE);
  assign bus_io.err        = (state_q == ST_ERR);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: two instances (DEPTH 64 and 4) share one directed stimulus.
// A program-level model predicts every output each cycle; literal checks pin known encodings.
module tb_instr_encoder_loader;
  localparam int AW = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ERR = 3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        t_start, t_stop, t_valid;
  logic [2:0]  t_op;
  logic [4:0]  t_rd, t_rs1, t_rs2;
  logic [12:0] t_imm;

  instr_encoder_loader_if #(.ADDR_W(AW)) if_a ();
  instr_encoder_loader_if #(.ADDR_W(AW)) if_b ();

  assign if_a.start = t_start;  assign if_b.start = t_start;
  assign if_a.stop = t_stop;    assign if_b.stop = t_stop;
  assign if_a.req_valid = t_valid; assign if_b.req_valid = t_valid;
  assign if_a.req_op = t_op;    assign if_b.req_op = t_op;
  assign if_a.req_rd = t_rd;    assign if_b.req_rd = t_rd;
  assign if_a.req_rs1 = t_rs1;  assign if_b.req_rs1 = t_rs1;
  assign if_a.req_rs2 = t_rs2;  assign if_b.req_rs2 = t_rs2;
  assign if_a.req_imm = t_imm;  assign if_b.req_imm = t_imm;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0), .DEPTH(64)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .bus_io(if_a));
  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0), .DEPTH(4)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .bus_io(if_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- program-level model ----------------
  // Instruction words built arithmetically from field weights.
  function automatic logic [31:0] model_enc(input int op, input int rd, input int rs1,
                                            input int rs2, input int imm);
    longint unsigned w;
    longint unsigned f3, f7;
    w = 0;
    if (op <= 3) begin
      f7 = (op == 1) ? 32 : 0;
      f3 = (op <= 1) ? 0 : ((op == 2) ? 7 : 6);
      w = f7 * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 51;
    end else if (op == 4) begin
      w = (imm % 4096) * 2**20 + rs1 * 2**15 + 3 * 2**12 + rd * 2**7 + 3;
    end else if (op == 5) begin
      w = ((imm / 32) % 128) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + 3 * 2**12
          + (imm % 32) * 2**7 + 35;
    end else if (op == 6) begin
      w = ((imm / 4096) % 2) * 2**31 + ((imm / 32) % 64) * 2**25 + rs2 * 2**20
          + rs1 * 2**15 + ((imm / 2) % 16) * 2**8 + ((imm / 2048) % 2) * 2**7 + 99;
    end
    return w[31:0];
  endfunction

  function automatic bit model_ok(input int op, input int imm);
    if (op == 7) return 1'b0;
    if (op == 4 || op == 5) return ((imm / 4096) % 2) == ((imm / 2048) % 2);
    if (op == 6) return (imm % 2) == 0;
    return 1'b1;
  endfunction

  int          dep [2]     = '{64, 4};
  int          m_st [2]    = '{M_IDLE, M_IDLE};
  int          m_iss [2]   = '{0, 0};   // legal requests taken this program
  int          m_cnt [2]   = '{0, 0};   // writes completed this program
  bit          m_pw [2]    = '{1'b0, 1'b0};
  int          m_paddr [2] = '{0, 0};
  logic [31:0] m_pdat [2]  = '{32'd0, 32'd0};
  bit          mb_rdy, mb_acc, mb_ok;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] = M_IDLE; m_iss[i] = 0; m_cnt[i] = 0; m_pw[i] = 1'b0;
        m_paddr[i] = 0; m_pdat[i] = 32'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        mb_rdy = (m_st[i] == M_RUN) && (m_iss[i] < dep[i]);
        mb_acc = mb_rdy && t_valid;
        mb_ok  = model_ok(int'(t_op), int'(t_imm));
        if (m_pw[i]) m_cnt[i]++;
        m_pw[i] = 1'b0;
        m_pdat[i] = 32'd0;
        if (mb_acc && mb_ok) begin
          // k-th legal request of a program lands at word BASE+k
          m_pw[i] = 1'b1;
          m_paddr[i] = m_iss[i];
          m_pdat[i] = model_enc(int'(t_op), int'(t_rd), int'(t_rs1), int'(t_rs2), int'(t_imm));
          m_iss[i]++;
        end
        if (m_st[i] == M_RUN) begin
          if (mb_acc && !mb_ok) m_st[i] = M_ERR;
          else if (t_stop)      m_st[i] = M_DONE;
        end else if (t_start) begin
          m_st[i] = M_RUN; m_iss[i] = 0; m_cnt[i] = 0;
        end
      end
    end
  end

  function automatic logic [63:0] exp_rdy(input int i);
    return 64'((m_st[i] == M_RUN) && (m_iss[i] < dep[i]));
  endfunction

  function automatic logic [63:0] exp_wr(input int i);
    logic [7:0] a;
    a = 8'(m_paddr[i]);
    return m_pw[i] ? 64'({1'b1, a, m_pdat[i]}) : 64'd0;
  endfunction

  function automatic logic [63:0] exp_st(input int i);
    logic [7:0] c;
    bit run;
    c = 8'(m_cnt[i]);
    run = (m_st[i] == M_RUN);
    return 64'({c, run, run && (m_cnt[i] == dep[i]), m_st[i] == M_DONE, m_st[i] == M_ERR});
  endfunction

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk_i) begin
    chk("ready_a",  64'(if_a.req_ready), exp_rdy(0));
    chk("write_a",  64'({if_a.imem_we, if_a.imem_addr, if_a.imem_wdata}), exp_wr(0));
    chk("status_a", 64'({if_a.count, if_a.busy, if_a.full, if_a.done, if_a.err}), exp_st(0));
    chk("ready_b",  64'(if_b.req_ready), exp_rdy(1));
    chk("write_b",  64'({if_b.imem_we, if_b.imem_addr, if_b.imem_wdata}), exp_wr(1));
    chk("status_b", 64'({if_b.count, if_b.busy, if_b.full, if_b.done, if_b.err}), exp_st(1));
  end

  // Record instance A's writes for literal checks.
  logic [39:0] wr_a [$];
  always @(negedge clk_i) begin
    if (if_a.imem_we === 1'b1) wr_a.push_back({if_a.imem_addr, if_a.imem_wdata});
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input int op, input int rd, input int rs1, input int rs2, input int imm);
    t_op = 3'(op); t_rd = 5'(rd); t_rs1 = 5'(rs1); t_rs2 = 5'(rs2); t_imm = 13'(imm);
    t_valid = 1'b1;
    cyc();
  endtask

  logic [31:0] lit2 [6] = '{32'h02813083, 32'h02113423, 32'h003100b3,
                            32'h403100b3, 32'h003170b3, 32'h003160b3};

  initial begin
    t_start = 0; t_stop = 0; t_valid = 0; t_op = 0; t_rd = 0; t_rs1 = 0; t_rs2 = 0; t_imm = 0;
    #1 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", 64'(if_a.req_ready), 64'd0);
    chk("rst_we", 64'(if_a.imem_we), 64'd0);
    chk("rst_count", 64'(if_a.count), 64'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    // stop in IDLE is ignored
    t_stop = 1; cyc(); t_stop = 0;

    // 1: single BEQ
    t_start = 1; cyc(); t_start = 0;
    req(6, 0, 1, 2, 40); t_valid = 0;
    @(negedge clk_i);
    chk("t1_we", 64'(if_a.imem_we), 64'd1);
    chk("t1_addr", 64'(if_a.imem_addr), 64'd0);
    chk("t1_wdata", 64'(if_a.imem_wdata), 64'h02208463);
    cyc();
    t_stop = 1; cyc(); t_stop = 0;
    @(negedge clk_i);
    chk("t1_done", 64'(if_a.done), 64'd1);
    chk("t1_count", 64'(if_a.count), 64'd1);

    // 2/3: six back-to-back requests; start held one extra cycle (ignored in RUN)
    t_start = 1; cyc(); cyc(); t_start = 0;
    req(4, 1, 2, 0, 40);
    req(5, 0, 2, 1, 40);
    req(0, 1, 2, 3, 0);
    req(1, 1, 2, 3, 0);
    req(2, 1, 2, 3, 0);
    req(3, 1, 2, 3, 0);
    t_valid = 0;
    cyc();
    @(negedge clk_i);
    chk("t2_count", 64'(if_a.count), 64'd6);
    chk("t2_nwrites", 64'(wr_a.size()), 64'd7);
    for (int k = 0; k < 6; k++) begin
      if (wr_a.size() > k + 1)
        chk("t2_word", 64'(wr_a[k+1]), 64'({8'(k), lit2[k]}));
    end
    chk("t3_full", 64'(if_b.full), 64'd1);
    chk("t3_ready", 64'(if_b.req_ready), 64'd0);
    cyc();
    t_stop = 1; cyc(); t_stop = 0;
    @(negedge clk_i);
    chk("t3_done", 64'(if_b.done), 64'd1);
    chk("t3_count", 64'(if_b.count), 64'd4);

    // 4: good ADD then illegal op; later requests are not taken
    cyc();
    t_start = 1; cyc(); t_start = 0;
    req(0, 1, 2, 3, 0);
    req(7, 1, 2, 3, 0);
    req(0, 4, 5, 6, 0);
    cyc();
    t_valid = 0;
    @(negedge clk_i);
    chk("t4_err", 64'(if_a.err), 64'd1);
    chk("t4_nwrites", 64'(wr_a.size()), 64'd8);
    if (wr_a.size() == 8) chk("t4_add", 64'(wr_a[7]), 64'({8'd0, 32'h003100b3}));
    cyc();
    t_start = 1; cyc(); t_start = 0;
    @(negedge clk_i);
    chk("t4_err_clr", 64'(if_a.err), 64'd0);
    chk("t4_busy", 64'(if_a.busy), 64'd1);
    chk("t4_count", 64'(if_a.count), 64'd0);

    // 5: misaligned BEQ, then out-of-range LD
    cyc();
    req(6, 0, 1, 2, 41); t_valid = 0;
    @(negedge clk_i);
    chk("t5_beq_err", 64'(if_a.err), 64'd1);
    chk("t5_beq_we", 64'(if_a.imem_we), 64'd0);
    cyc();
    t_start = 1; cyc(); t_start = 0;
    req(4, 1, 2, 0, 13'h0800); t_valid = 0;
    @(negedge clk_i);
    chk("t5_ld_err", 64'(if_a.err), 64'd1);
    chk("t5_ld_we", 64'(if_a.imem_we), 64'd0);

    // stop with handshake, then start while that write is still pending
    cyc();
    t_start = 1; cyc(); t_start = 0;
    t_stop = 1; req(2, 7, 8, 9, 0); t_valid = 0; t_stop = 0;
    @(negedge clk_i);
    chk("stop_done", 64'(if_a.done), 64'd1);
    chk("stop_write", 64'({if_a.imem_we, if_a.imem_addr, if_a.imem_wdata}),
        64'({1'b1, 8'd0, 32'h009473b3}));
    t_start = 1; cyc(); t_start = 0;
    @(negedge clk_i);
    chk("restart_busy", 64'(if_a.busy), 64'd1);
    chk("restart_count", 64'(if_a.count), 64'd0);

    // 6: reset lands while a write is due
    cyc();
    req(1, 1, 2, 3, 0); t_valid = 0;
    #2 rst_i = 1'b1;
    #1;
    chk("t6_we", 64'(if_a.imem_we), 64'd0);
    chk("t6_busy", 64'(if_a.busy), 64'd0);
    chk("t6_ready", 64'(if_a.req_ready), 64'd0);
    chk("t6_count", 64'(if_a.count), 64'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    cyc(); cyc();
    @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
